snow64_vec_div_u16_by_u8_seq: RTL and testbench

SNOW64_VEC_DIV_U16_BY_U8_SEQ -- requirements
Module: snow64_vec_div_u16_by_u8_seq

---
 rtl/snow64_vec_div_u16_by_u8_seq_pkg.sv | 8 +
 rtl/snow64_vec_div_u16_by_u8_seq.sv | 101 ++++++++++
 tb/tb_snow64_vec_div_u16_by_u8_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/snow64_vec_div_u16_by_u8_seq_pkg.sv
// snow64_vec_div_u16_by_u8_seq_pkg: lane count default, lane widths and FSM states for the vector divider sequencer
package PkgSnow64LongDiv;
  localparam int NUM_LANES_DEF = 4;
  localparam int A_W = 16;
  localparam int B_W = 8;
  localparam int DIV_Q_W = 18;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/snow64_vec_div_u16_by_u8_seq.sv
// snow64_vec_div_u16_by_u8_seq: sequences a NUM_LANES u16/u8 vector divide through one shared external divider
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b request; out_valid/out_ready/out_data/out_dbz result;
//        div_start/div_a/div_b command to the divider; div_can_accept_cmd/div_valid/div_data response from it.
module snow64_vec_div_u16_by_u8_seq
  import PkgSnow64LongDiv::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_W*NUM_LANES-1:0]   in_a,
  input  logic [B_W*NUM_LANES-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_W*NUM_LANES-1:0]   out_data,
  output logic [NUM_LANES-1:0]       out_dbz,
  output logic                       div_start,
  output logic [A_W-1:0]             div_a,
  output logic [B_W-1:0]             div_b,
  input  logic                       div_can_accept_cmd,
  input  logic                       div_valid,
  input  logic [DIV_Q_W-1:0]         div_data
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  state_t                     r_state;
  logic [LW-1:0]              r_lane;
  logic [A_W*NUM_LANES-1:0]   r_a;
  logic [B_W*NUM_LANES-1:0]   r_b;
  logic [A_W*NUM_LANES-1:0]   r_q;
  logic [NUM_LANES-1:0]       r_dbz;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [A_W-1:0]             r_div_a;
  logic [B_W-1:0]             r_div_b;
  logic [LW-1:0]              w_nxt;
  logic                       w_last;
  logic                       w_unused_hi;
  assign w_nxt       = r_lane + 1'b1;
  assign w_last      = r_lane == LW'(NUM_LANES - 1);
  assign w_unused_hi = ^div_data[DIV_Q_W-1:A_W];
  // Start is gated by the divider's idle flag so a divider left busy across our reset is never re-commanded early.
  assign div_start = (r_state == ST_ISSUE) && div_can_accept_cmd;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_q;
  assign out_dbz   = r_dbz;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lane      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_q         <= '0;
      r_dbz       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_lane     <= '0;
            r_div_a    <= in_a[A_W-1:0];
            r_div_b    <= in_b[B_W-1:0];
            r_in_ready <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        ST_ISSUE:
          if (div_can_accept_cmd) r_state <= ST_WAIT;
        // div_valid is only looked at here; the divider drops any stale level on the start edge that precedes WAIT.
        ST_WAIT:
          if (div_valid) begin
            r_q[A_W*r_lane +: A_W] <= div_data[A_W-1:0];
            r_dbz[r_lane]          <= r_b[B_W*r_lane +: B_W] == '0;
            if (w_last) r_state <= ST_DONE;
            else begin
              r_lane  <= w_nxt;
              r_div_a <= r_a[A_W*w_nxt +: A_W];
              r_div_b <= r_b[B_W*w_nxt +: B_W];
              r_state <= ST_ISSUE;
            end
          end
        // out_valid is raised one edge after entering DONE so it comes straight from a flop.
        ST_DONE:
          if (!r_out_valid) r_out_valid <= 1'b1;
          else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_snow64_vec_div_u16_by_u8_seq.sv
// tb_snow64_vec_div_u16_by_u8_seq: scoreboard bench with a 6-working-edge divider model
module tb_snow64_vec_div_u16_by_u8_seq;
  localparam int N = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, div_start, div_can_accept_cmd, div_valid;
  logic [16*N-1:0] in_a = '0, out_data;
  logic [8*N-1:0] in_b = '0;
  logic [N-1:0] out_dbz;
  logic [15:0] div_a;
  logic [7:0] div_b;
  logic [17:0] div_data;
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, nstart = 0, st0 = 0;
  logic lat_chk = 0, slow = 0, busy = 0, dv = 0, ov_prev = 0;
  logic [2:0] cnt = 0;
  logic [17:0] dd = 0;
  typedef struct { logic [63:0] d; logic [3:0] z; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  snow64_vec_div_u16_by_u8_seq #(.NUM_LANES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dbz(out_dbz),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_can_accept_cmd(div_can_accept_cmd),
    .div_valid(div_valid), .div_data(div_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign div_can_accept_cmd = !busy && !slow;
  assign div_valid = dv;
  assign div_data = dd;
  always @(posedge clk)
    if (div_start && div_can_accept_cmd) begin
      busy <= 1;
      cnt <= 3'd6;
      dv <= 0;
      dd <= {2'b11, ((div_b == 8'd0) ? 16'd0 : div_a / {8'd0, div_b})};
    end else if (busy) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) begin
        busy <= 0;
        dv <= 1;
      end
    end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (div_start) nstart <= nstart + 1;
    if (out_valid && !ov_prev && lat_chk) chk("latency", 64'(cyc - acc_cyc), 64'd33);
    ov_prev <= out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 64'(q.size()), 64'd1);
      else begin
        mon_e = q.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_dbz", 64'(out_dbz), 64'(mon_e.z));
        chk("div_start_count", 64'(nstart - st0), 64'(N));
      end
    end
  end
  task automatic send(input logic [63:0] a, input logic [31:0] b, input logic [63:0] ed, input logic [3:0] ez);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(in_ready), 64'd1);
    if (!in_ready) begin
      in_valid = 0;
      return;
    end
    e.d = ed;
    e.z = ez;
    q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    st0 = nstart;
    in_valid = 0;
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask
  task automatic chk_reset;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);
    chk("rst_div_b", 64'(div_b), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_dbz", 64'(out_dbz), 64'd0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1;
    lat_chk = 1;
    send({16'd7, 16'd65535, 16'd255, 16'd1000}, {8'd8, 8'd255, 8'd1, 8'd10},
         {16'd0, 16'd257, 16'd255, 16'd100}, 4'b0000);
    drain();
    send({16'd300, 16'd1234, 16'd200, 16'd100}, {8'd150, 8'd0, 8'd7, 8'd5},
         {16'd2, 16'd0, 16'd28, 16'd20}, 4'b0100);
    drain();
    out_ready = 0;
    send({16'd40000, 16'd999, 16'd16, 16'd0}, {8'd200, 8'd3, 8'd16, 8'd1},
         {16'd200, 16'd333, 16'd1, 16'd0}, 4'b0000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", 64'(out_valid), 64'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, {16'd200, 16'd333, 16'd1, 16'd0});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_div_start", 64'(div_start), 64'd0);
    end
    out_ready = 1;
    drain();
    lat_chk = 0;
    slow = 1;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    send({16'd500, 16'd300, 16'd200, 16'd100}, {8'd7, 8'd9, 8'd0, 8'd10},
         {16'd71, 16'd33, 16'd0, 16'd10}, 4'b0010);
    repeat (5) begin
      @(negedge clk);
      chk("slow_no_start", 64'(div_start), 64'd0);
    end
    slow = 0;
    drain();
    send({16'd9000, 16'd8000, 16'd7000, 16'd6000}, {8'd1, 8'd1, 8'd1, 8'd1},
         {16'd9000, 16'd8000, 16'd7000, 16'd6000}, 4'b0000);
    while (cyc < acc_cyc + 11) @(negedge clk);
    rst_n = 0;
    #1;
    chk_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1;
    send({16'd6, 16'd6, 16'd6, 16'd6}, {8'd3, 8'd3, 8'd3, 8'd3},
         {16'd2, 16'd2, 16'd2, 16'd2}, 4'b0000);
    drain();
    lat_chk = 1;
    for (int v = 0; v < 1000; v++) begin
      logic [63:0] a, ed;
      logic [31:0] b;
      logic [3:0] ez;
      a = {$urandom, $urandom};
      for (int k = 0; k < N; k++) begin
        b[8*k +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        ez[k] = b[8*k +: 8] == 8'd0;
        ed[16*k +: 16] = ez[k] ? 16'd0 : a[16*k +: 16] / {8'd0, b[8*k +: 8]};
      end
      send(a, b, ed, ez);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
